clk_period_meter: RTL

Measures an incoming square wave, typically the output of the team's clock dividers, against the 50 MHz system clock. It reports the period and high time in clkin cycles, plus a one-cycle valid strobe per completed period. It sits on the receiving side of any divided-clock path and serves as the bench/board check that divider outputs have the intended frequency and duty.

---
 rtl/clk_period_meter_pkg.sv | 6 +
 rtl/clk_period_meter_sync_edge_det.sv | 44 ++++
 rtl/clk_period_meter.sv | 74 +++++++
 3 files changed

// File: rtl/clk_period_meter_pkg.sv
// clk_period_meter_pkg: shared state encoding and default sizing for clk_period_meter
package clk_period_meter_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [31:0] MAX_CNT_DEF = 32'd50_000_000;
  localparam int CW_DEF = 32;
endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser with rise/fall pulses for any asynchronous input
// Optional stability filter enabled by CLK_PERIOD_METER_GLITCH_FILTER_EN.
module sync_edge_det #(
  parameter int FILT_LEN = 4
) (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic s1, s2, s_d;
  always_ff @(posedge clkin) begin
    s1 <= reset ? d : 1'b0;
    s2 <= reset ? s1 : 1'b0;
  end
`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] fc;
  logic f;
  // accept a new level only after FILT_LEN consecutive cycles of disagreement
  always_ff @(posedge clkin) begin
    if (!reset) begin
      f <= 1'b0;
      fc <= '0;
    end else if (s2 == f) begin
      fc <= '0;
    end else if (fc == FW'(FILT_LEN - 1)) begin
      f <= s2;
      fc <= '0;
    end else begin
      fc <= fc + 1'b1;
    end
  end
  assign lvl = f;
`else
  localparam int unused_filt_len = FILT_LEN;
  assign lvl = s2;
`endif
  always_ff @(posedge clkin) s_d <= reset ? lvl : 1'b0;
  assign rise = lvl & ~s_d;
  assign fall = ~lvl & s_d;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of sig_in in clkin cycles, with timeout
// Optional input glitch filter enabled by CLK_PERIOD_METER_GLITCH_FILTER_EN.
import clk_period_meter_pkg::*;
module clk_period_meter #(
  parameter logic [31:0] MAX_CNT = MAX_CNT_DEF,
  parameter int CW = CW_DEF,
  parameter int FILT_LEN = 4
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          sig_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          timeout
);
  localparam logic [CW-1:0] LIM = CW'(MAX_CNT);
  state_t state, state_n;
  logic [CW-1:0] cnt, hi_lat;
  logic rise, fall, unused_lvl, at_lim, tmo;
  sync_edge_det #(.FILT_LEN(FILT_LEN)) u_sync (
    .clkin(clkin),
    .reset(reset),
    .d(sig_in),
    .lvl(unused_lvl),
    .rise(rise),
    .fall(fall)
  );
  assign at_lim = cnt == LIM;
  // a rise at the limit still closes the period; only an edge-free limit cycle times out
  always_comb begin
    state_n = state;
    tmo = 1'b0;
    case (state)
      IDLE: state_n = rise ? HIGH : IDLE;
      HIGH: begin
        tmo = at_lim & ~rise & ~fall;
        state_n = rise ? HIGH : fall ? LOW : tmo ? IDLE : HIGH;
      end
      LOW: begin
        tmo = at_lim & ~rise;
        state_n = rise ? HIGH : tmo ? IDLE : LOW;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clkin) state <= reset ? state_n : IDLE;
  always_ff @(posedge clkin) begin
    if (!reset) begin
      cnt <= '0;
      hi_lat <= '0;
      period <= '0;
      high_time <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        cnt <= CW'(1);
        if (state != IDLE) begin
          period <= cnt;
          high_time <= (state == HIGH) ? cnt : hi_lat;
          valid <= 1'b1;
          timeout <= 1'b0;
        end
      end else if (tmo) begin
        timeout <= 1'b1;
      end else if (state != IDLE) begin
        if (fall && state == HIGH) hi_lat <= cnt;
        cnt <= at_lim ? cnt : cnt + 1'b1;
      end
    end
  end
endmodule
